// File: rtl/matrix_stream_loader.sv
// matrix_stream_loader
//   Streaming front end for the combinational 6x6 matrix calculator. Collects
//   72 operand words (A row-major, then B row-major) from a valid/ready input
//   stream into two register banks that drive the calculator. It then waits a
//   programmable settle interval, captures the calculator result and offers it
//   on a valid/ready output stream.
//
//   Handshakes: a word or result moves on a rising edge where valid && ready.
//   Valid never depends on ready and ready never depends on valid. Once valid
//   is raised it stays high, with stable data, until the transfer edge.
//
//   Ports:
//     clk, rst_n         clock, asynchronous active-low reset
//     clr                synchronous soft clear (abandons the current load)
//     in_valid/in_ready/in_data     operand word stream
//     mat_a, mat_b       A/B banks, element [r][c] at (r*6+c)*DATA_W
//     calc_result        combinational result from the calculator
//     out_valid/out_ready/out_data  result stream
//     checksum           running sum of the words in this load
//                        (only when LOADER_CHECKSUM_EN is defined)
//     busy               high whenever the FSM is not in LOAD
//     dbg_state          current FSM state (0 LOAD, 1 SETTLE, 2 HOLD)
//
//   Optional feature macro: LOADER_CHECKSUM_EN
module matrix_stream_loader #(
  parameter int DATA_W        = 32,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  output logic [36*DATA_W-1:0] mat_a,
  output logic [36*DATA_W-1:0] mat_b,
  input  logic [DATA_W-1:0]    calc_result,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_data,
`ifdef LOADER_CHECKSUM_EN
  output logic [DATA_W-1:0]    checksum,
`endif
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_e;

  localparam logic [7:0] SETTLE_M1 = 8'(SETTLE_CYCLES - 1);

  state_e                state_q, state_d;
  logic [6:0]            idx_q;
  logic [7:0]            settle_q;
  logic                  out_valid_q;
  logic [DATA_W-1:0]     out_data_q;
  logic [36*DATA_W-1:0]  mat_a_q, mat_b_q;

  logic in_xfer, out_xfer, last_word, settle_done;

  assign in_xfer     = in_valid && in_ready;
  assign out_xfer    = out_valid_q && out_ready;
  assign last_word   = (idx_q == 7'd71);
  assign settle_done = (settle_q == 8'd0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_LOAD;
    else        state_q <= state_d;
  end

  // Next-state logic; clr overrides every transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD:   if (in_xfer && last_word) state_d = ST_SETTLE;
      ST_SETTLE: if (settle_done)          state_d = ST_HOLD;
      ST_HOLD:   if (out_xfer)             state_d = ST_LOAD;
      default:                             state_d = ST_LOAD;
    endcase
    if (clr) state_d = ST_LOAD;
  end

  // Outputs decoded from the registered state only
  always_comb begin
    in_ready  = (state_q == ST_LOAD);
    busy      = (state_q != ST_LOAD);
    dbg_state = state_q;
  end

  // Index, settle counter and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      settle_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (clr) begin
      idx_q       <= '0;
      settle_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (in_xfer) begin
            idx_q <= last_word ? 7'd0 : 7'(idx_q + 7'd1);
            if (last_word) settle_q <= SETTLE_M1;
          end
        end
        ST_SETTLE: begin
          if (settle_done) begin
            out_data_q  <= calc_result;
            out_valid_q <= 1'b1;
          end else begin
            settle_q <= 8'(settle_q - 8'd1);
          end
        end
        ST_HOLD: begin
          if (out_xfer) out_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Operand banks: only the element addressed by the current index changes.
  // clr suppresses a same-cycle write; bank contents survive clr and results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mat_a_q <= '0;
      mat_b_q <= '0;
    end else if (!clr && in_xfer) begin
      for (int e = 0; e < 36; e++) begin
        if (idx_q == 7'(e))      mat_a_q[e*DATA_W +: DATA_W] <= in_data;
        if (idx_q == 7'(e + 36)) mat_b_q[e*DATA_W +: DATA_W] <= in_data;
      end
    end
  end

  assign mat_a     = mat_a_q;
  assign mat_b     = mat_b_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

`ifdef LOADER_CHECKSUM_EN
  // Transfers only happen in LOAD, so the sum freezes naturally from the
  // word-71 edge until the output handshake clears it.
  logic [DATA_W-1:0] sum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        sum_q <= '0;
    else if (clr)      sum_q <= '0;
    else if (in_xfer)  sum_q <= sum_q + in_data;
    else if (out_xfer) sum_q <= '0;
  end

  assign checksum = sum_q;
`endif

endmodule

// File: doc/matrix_stream_loader.md
# matrix_stream_loader

Sequential front end for the combinational 6x6 matrix calculator (`calc`). It accepts the 72 operand words of matrices A and B as a serial valid/ready stream and holds them in two register banks that drive `calc`'s parallel inputs. After a programmable settle interval it samples `calc`'s 32-bit result and returns it on an output valid/ready stream. It replaces testbench-style direct matrix assignment when `calc` is driven from a streaming source.

## Interface
- `DATA_W`, default 32: width of each matrix element and of the result.
- `SETTLE_CYCLES`, default 2: clock cycles between acceptance of the last word and result capture; legal range 1..255.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `clr`  in  1  synchronous soft clear; abandons the current load.
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  loader can accept a word.
- `in_data`  in  DATA_W  operand word.
- `mat_a`  out  36*DATA_W  A bank; element [r][c] at bits `(r*6+c)*DATA_W +: DATA_W`; wired to `calc`'s A inputs.
- `mat_b`  out  36*DATA_W  B bank, same packing; wired to `calc`'s B inputs.
- `calc_result`  in  DATA_W  combinational result returned from `calc`.
- `out_valid`  out  1  captured result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  DATA_W  captured result.
- `busy`  out  1  high whenever the state is not LOAD.

## Operation
- States: LOAD, SETTLE, HOLD. Reset state is LOAD.
- Reset values: index counter 0; `in_ready` 1; `out_valid` 0; `out_data` 0; `busy` 0; `mat_a` and `mat_b` all zero; settle counter 0.
- LOAD:
  - `in_ready` is 1.
  - A word transfers when `in_valid && in_ready`.
  - Word index k = 0..35 is written to A[k/6][k%6]; k = 36..71 is written to B[(k-36)/6][(k-36)%6].
  - Only the addressed element changes; all other elements keep their previous value.
  - The index counter increments per transfer. The transfer of k = 71 moves the state to SETTLE and resets the index to 0.
- SETTLE:
  - `in_ready` is 0 and `in_valid` is ignored.
  - The settle counter is loaded with `SETTLE_CYCLES-1` on entry and decrements each cycle.
  - The edge on which the counter equals 0 captures `calc_result` into `out_data`, sets `out_valid`, and moves the state to HOLD.
- HOLD:
  - `out_valid` and `out_data` stay stable until `out_valid && out_ready`.
  - On that edge: `out_valid` goes to 0, the state returns to LOAD, and `in_ready` is 1 from that edge on.
- Banks keep their contents across results, so a new load overwrites them element by element.
- `clr` has priority over every transfer in the same cycle. It forces: state LOAD, index 0, `out_valid` 0, settle counter 0. Banks and `out_data` are retained.
- `rst_n` low at any time, including mid-load or mid-settle, immediately forces all reset values.

## Timing
- Input throughput: 1 word per cycle. A full load with continuous `in_valid` takes 72 cycles.
- Let edge N be the edge that transfers word 71.
  - `busy` is 1 from edge N.
  - `calc_result` is sampled at edge N+SETTLE_CYCLES; `out_valid` is 1 from that edge.
- `calc` must settle within `SETTLE_CYCLES` clock periods. This is a timing constraint on the integrator.
- Zero-bubble turnaround: a word may be accepted in the cycle immediately after the output handshake edge.
- `in_ready` does not depend combinationally on `in_valid`. `out_valid` does not depend combinationally on `out_ready`.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - Adds output port `checksum` (DATA_W bits, reset 0): a running sum, modulo 2^DATA_W, of all words transferred in the current load.
  - The sum is cleared by `clr`, and on the output handshake edge.
  - It is frozen from edge N through HOLD, so it is valid whenever `out_valid` is 1.
- Undefined: no `checksum` port and no accumulator logic; all other behaviour is identical.

## Test plan
- Fill order: 72 words all equal to 3, continuous `in_valid`, bench drives `calc_result`=32'h1234, `SETTLE_CYCLES`=2, `out_ready`=1.
  - Every element of `mat_a` and `mat_b` is 3.
  - `out_valid` rises 2 edges after the word-71 edge with `out_data`=32'h1234.
  - `checksum`=216 (when enabled).
- Ordering: word k = k → A[1][1] slice = 7, B[0][0] slice = 36, B[5][5] slice = 71.
- Input backpressure: `in_valid` toggles every cycle → exactly 72 transfers complete the load; `in_ready` is 0 throughout SETTLE and HOLD.
- Output backpressure: `out_ready` held 0 for 5 cycles → `out_valid`=1 and `out_data` stable all 5 cycles. `out_ready` then set to 1 → `in_ready`=1 from the handshake edge.
- Soft clear: `clr` pulsed after 10 words → next word lands in A[0][0]; elements A[0][1]..A[1][3] keep their loaded values.
- Async reset during SETTLE: all outputs return to reset values without waiting for a clock edge. Checksum wrap: 72 words of 32'hFFFFFFFF → `checksum`=32'hFFFFFFB8.
